// File: rtl/adder_pkg.sv
// Shared constants and types for the adder/subtractor family.
// The bit-serial subtractor takes its operand width, counter width and FSM states from here.
package adder_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fs_state_t;

endpackage

// File: rtl/bit8_serial_fs_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
// The master drives the request and the slave (the subtractor) returns the results.
interface bit8_serial_fs_if;
  import adder_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, overflow, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, overflow, busy, done
  );

endinterface

// File: rtl/full_subtractor.sv
// Purely combinational 1-bit full subtractor computing a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow out when b exceeds a, or when the bits are equal and a borrow arrives
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit8_serial_fs.sv
// Bit-serial 8-bit subtractor: computes a - b - bin LSB first through one full-subtractor cell,
// eight cycles per operation, with results registered only on completion.
module bit8_serial_fs
  import adder_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  bit8_serial_fs_if.slave bus
);

  fs_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             br_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic             d_s;
  logic             br_next_s;
  logic [WIDTH-1:0] res_next_s;

  full_subtractor u_fs (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (br_r),
    .diff (d_s),
    .bout (br_next_s)
  );

  // New difference bit enters at the MSB so the result lines up after eight shifts
  assign res_next_s = {d_s, res_sr_r[WIDTH-1:1]};

  // Control FSM, operand/result shift registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      a_sr_r     <= {WIDTH{1'b0}};
      b_sr_r     <= {WIDTH{1'b0}};
      res_sr_r   <= {WIDTH{1'b0}};
      br_r       <= 1'b0;
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
      diff_r     <= {WIDTH{1'b0}};
      bout_r     <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sr_r  <= bus.a;
            b_sr_r  <= bus.b;
            br_r    <= bus.bin;
            a_msb_r <= bus.a[WIDTH-1];
            b_msb_r <= bus.b[WIDTH-1];
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= res_next_s;
          br_r     <= br_next_s;
          cnt_r    <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            // Overflow uses the latched operand signs; d_s is the final result MSB
            diff_r     <= res_next_s;
            bout_r     <= br_next_s;
            overflow_r <= (a_msb_r != b_msb_r) && (d_s != a_msb_r);
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= DONE;
          end else begin
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff     = diff_r;
  assign bus.bout     = bout_r;
  assign bus.overflow = overflow_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_bit8_serial_fs.sv
// Directed self-checking bench for bit8_serial_fs: reset, arithmetic vectors,
// mid-operation start/reset and back-to-back operation.
module tb_bit8_serial_fs;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  bit8_serial_fs_if bus ();

  bit8_serial_fs dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request, then scramble the operands so later changes must be ignored
  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic binv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.bin   = binv;
    tick();
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.bin   = ~binv;
  endtask

  // Measure cycles to done, busy-high cycles and whether diff stayed stable meanwhile
  task automatic wait_done(output int lat, output int busy_cycles, output bit held);
    logic [7:0] d0;
    d0          = bus.diff;
    lat         = -1;
    busy_cycles = bus.busy ? 1 : 0;
    held        = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) busy_cycles++;
      if (bus.diff !== d0) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h01;
    bus.bin   = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (bus.diff !== 8'h00) $display("FAIL reset_diff: got %h expected 00", bus.diff); else pass_cnt++;
    total_cnt++;
    if ({bus.bout, bus.overflow} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {bus.bout, bus.overflow}); else pass_cnt++;
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); else pass_cnt++;
    total_cnt++;
    if (dut.state_r !== IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.state_r, IDLE); else pass_cnt++;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_vector(input string name, input logic [7:0] av, input logic [7:0] bv,
                             input logic binv, input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    int bcyc;
    bit held;
    accept(av, bv, binv);
    wait_done(lat, bcyc, held);
    total_cnt++;
    if (lat !== 8) $display("FAIL %s_latency: got %0d expected 8", name, lat); else pass_cnt++;
    total_cnt++;
    if (bcyc !== 8) $display("FAIL %s_busy_cycles: got %0d expected 8", name, bcyc); else pass_cnt++;
    total_cnt++;
    if (held !== 1'b1) $display("FAIL %s_partial_visible: got %b expected 1", name, held); else pass_cnt++;
    total_cnt++;
    if (bus.diff !== ed) $display("FAIL %s_diff: got %h expected %h", name, bus.diff, ed); else pass_cnt++;
    total_cnt++;
    if (bus.bout !== eb) $display("FAIL %s_bout: got %b expected %b", name, bus.bout, eb); else pass_cnt++;
    total_cnt++;
    if (bus.overflow !== eo) $display("FAIL %s_overflow: got %b expected %b", name, bus.overflow, eo); else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.done, bus.busy, bus.diff} !== {2'b00, ed}) $display("FAIL %s_after_done: got %b/%b/%h expected 0/0/%h", name, bus.done, bus.busy, bus.diff, ed); else pass_cnt++;
  endtask

  task automatic test_arith();
    test_vector("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    test_vector("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    test_vector("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    test_vector("v00_00_bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    test_vector("v7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
  endtask

  task automatic test_start_in_shift();
    int lat;
    int bcyc;
    bit held;
    accept(8'h05, 8'h03, 1'b0);
    tick();
    tick();
    bus.start = 1'b1;
    bus.a     = 8'hFF;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;
    tick();
    bus.start = 1'b0;
    wait_done(lat, bcyc, held);
    total_cnt++;
    if (lat + 3 !== 8) $display("FAIL midstart_latency: got %0d expected 8", lat + 3); else pass_cnt++;
    total_cnt++;
    if (bus.diff !== 8'h02) $display("FAIL midstart_diff: got %h expected 02", bus.diff); else pass_cnt++;
    tick();
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL midstart_ignored: got %b expected 00", {bus.busy, bus.done}); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int pulses;
    accept(8'h80, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if ({bus.diff, bus.bout, bus.overflow, bus.busy, bus.done} !== 12'h000) $display("FAIL abort_outputs: got %h/%b%b%b%b expected 00/0000", bus.diff, bus.bout, bus.overflow, bus.busy, bus.done); else pass_cnt++;
    total_cnt++;
    if (dut.state_r !== IDLE) $display("FAIL abort_state: got %0d expected %0d", dut.state_r, IDLE); else pass_cnt++;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    total_cnt++;
    if (pulses !== 0) $display("FAIL abort_no_done: got %0d expected 0", pulses); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    int bcyc;
    bit held;
    accept(8'h10, 8'h01, 1'b0);
    wait_done(lat1, bcyc, held);
    total_cnt++;
    if ({bus.done, bus.diff} !== {1'b1, 8'h0F}) $display("FAIL b2b_first: got %b/%h expected 1/0f", bus.done, bus.diff); else pass_cnt++;
    accept(8'h20, 8'h02, 1'b0);
    total_cnt++;
    if ({bus.done, bus.busy} !== 2'b01) $display("FAIL b2b_done_falls: got %b expected 01", {bus.done, bus.busy}); else pass_cnt++;
    wait_done(lat2, bcyc, held);
    total_cnt++;
    if (lat2 + 1 !== 9) $display("FAIL b2b_spacing: got %0d expected 9", lat2 + 1); else pass_cnt++;
    total_cnt++;
    if ({bus.done, bus.diff, bus.bout} !== {1'b1, 8'h1E, 1'b0}) $display("FAIL b2b_second: got %b/%h/%b expected 1/1e/0", bus.done, bus.diff, bus.bout); else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL b2b_second_pulse: got %b expected 0", bus.done); else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.bin   = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_arith();
    test_start_in_shift();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
